// File: rtl/search_ctrl_pkg.sv
// Shared definitions for the bin search controller: default sizes, state
// encoding and result codes.
package search_ctrl_pkg;

  localparam int DEF_NUM_VARS  = 8;
  localparam int DEF_WIDTH_LVL = 16;
  localparam int DEF_WIDTH_CNT = 16;
  localparam int DEF_TIMEOUT   = 1024;

  // 4-bit state encoding, kept as named constants so checkers and the
  // debug port can refer to the same values as the FSM.
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_BCP      = 4'd1;
  localparam logic [3:0] ST_WAIT_BCP = 4'd2;
  localparam logic [3:0] ST_DECIDE   = 4'd3;
  localparam logic [3:0] ST_WAIT_DCD = 4'd4;
  localparam logic [3:0] ST_ANALYZE  = 4'd5;
  localparam logic [3:0] ST_WAIT_AN  = 4'd6;
  localparam logic [3:0] ST_BKT      = 4'd7;
  localparam logic [3:0] ST_DONE     = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE     = ST_IDLE,
    S_BCP      = ST_BCP,
    S_WAIT_BCP = ST_WAIT_BCP,
    S_DECIDE   = ST_DECIDE,
    S_WAIT_DCD = ST_WAIT_DCD,
    S_ANALYZE  = ST_ANALYZE,
    S_WAIT_AN  = ST_WAIT_AN,
    S_BKT      = ST_BKT,
    S_DONE     = ST_DONE
  } state_t;

  // Result codes; bit positions of the one-hot result vector
  // {timeout, bkt_out, unsat, sat}.
  localparam logic [1:0] RES_SAT     = 2'd0;
  localparam logic [1:0] RES_UNSAT   = 2'd1;
  localparam logic [1:0] RES_BKT_OUT = 2'd2;
  localparam logic [1:0] RES_TIMEOUT = 2'd3;

  function automatic logic [3:0] result_onehot(input logic [1:0] code);
    result_onehot = 4'b0001 << code;
  endfunction

endpackage

// File: rtl/search_ctrl_if.sv
// Bus between the search controller and its bin manager / engines.
//
// Handshake semantics: every *_start / *_pulse / apply_bkt_o output is a
// registered request exactly one cycle wide. The addressed unit answers with a
// one-cycle *_done_i; data qualified by a done (conflict_i, index_decided_i,
// bkt_lvl_i) is only sampled in the cycle the done is high, and a done is only
// honoured while the controller waits for it. done_o stays high with a valid
// one-hot result until the next accepted start_i.
interface search_ctrl_if import search_ctrl_pkg::*; #(
  parameter int NUM_VARS  = DEF_NUM_VARS,
  parameter int WIDTH_LVL = DEF_WIDTH_LVL,
  parameter int WIDTH_CNT = DEF_WIDTH_CNT
);
  logic                 start_i;
  logic [WIDTH_LVL-1:0] base_lvl_i;
  logic                 decision_pulse_o;
  logic                 decision_done_i;
  logic [NUM_VARS-1:0]  index_decided_i;
  logic [WIDTH_LVL-1:0] cur_lvl_i;
  logic                 bcp_start_o;
  logic                 bcp_done_i;
  logic                 conflict_i;
  logic                 analyze_start_o;
  logic                 analyze_done_i;
  logic [WIDTH_LVL-1:0] bkt_lvl_i;
  logic                 apply_bkt_o;
  logic [WIDTH_LVL-1:0] bkt_lvl_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 sat_o;
  logic                 unsat_o;
  logic                 bkt_out_o;
  logic                 timeout_o;
  logic [WIDTH_CNT-1:0] n_decisions_o;
  logic [WIDTH_CNT-1:0] n_conflicts_o;
  logic [3:0]           dbg_state_o;

  // Controller side
  modport master (
    input  start_i, base_lvl_i, decision_done_i, index_decided_i, cur_lvl_i,
           bcp_done_i, conflict_i, analyze_done_i, bkt_lvl_i,
    output decision_pulse_o, bcp_start_o, analyze_start_o, apply_bkt_o,
           bkt_lvl_o, busy_o, done_o, sat_o, unsat_o, bkt_out_o, timeout_o,
           n_decisions_o, n_conflicts_o, dbg_state_o
  );

  // Bin manager / engine side
  modport slave (
    output start_i, base_lvl_i, decision_done_i, index_decided_i, cur_lvl_i,
           bcp_done_i, conflict_i, analyze_done_i, bkt_lvl_i,
    input  decision_pulse_o, bcp_start_o, analyze_start_o, apply_bkt_o,
           bkt_lvl_o, busy_o, done_o, sat_o, unsat_o, bkt_out_o, timeout_o,
           n_decisions_o, n_conflicts_o, dbg_state_o
  );
endinterface

// File: rtl/search_ctrl_watchdog.sv
// Cycle counter guarding the WAIT_* states; expired_o is high in the cycle the
// count reaches TIMEOUT-1.
module ctrl_watchdog import search_ctrl_pkg::*; #(
  parameter int WIDTH_CNT = DEF_WIDTH_CNT,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  localparam logic [WIDTH_CNT-1:0] LIMIT = WIDTH_CNT'(TIMEOUT - 1);

  logic [WIDTH_CNT-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and park at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + WIDTH_CNT'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LIMIT);
endmodule

// File: rtl/search_ctrl.sv
// Per-bin CDCL sequencer: BCP -> decide -> BCP ..., and on conflict
// analyse -> backtrack -> BCP, until SAT, UNSAT, out-of-bin backtrack or timeout.
module search_ctrl import search_ctrl_pkg::*; #(
  parameter int NUM_VARS  = DEF_NUM_VARS,
  parameter int WIDTH_LVL = DEF_WIDTH_LVL,
  parameter int WIDTH_CNT = DEF_WIDTH_CNT,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input logic          clk,
  input logic          rst,
  search_ctrl_if.master bus
);
  localparam logic [WIDTH_CNT-1:0] CNT_MAX = {WIDTH_CNT{1'b1}};

  state_t               state_q, state_d;
  logic                 dec_pulse_q, dec_pulse_d;
  logic                 bcp_start_q, bcp_start_d;
  logic                 an_start_q, an_start_d;
  logic                 apply_q, apply_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [3:0]           res_q, res_d;
  logic [WIDTH_LVL-1:0] bkt_lvl_q, bkt_lvl_d;
  logic [WIDTH_CNT-1:0] n_dec_q, n_dec_d;
  logic [WIDTH_CNT-1:0] n_conf_q, n_conf_d;

  logic in_wait, wd_clear, wd_expired;

  // The watchdog only runs inside a WAIT_* state and restarts on any move.
  assign in_wait  = (state_q == S_WAIT_BCP) || (state_q == S_WAIT_DCD) ||
                    (state_q == S_WAIT_AN);
  assign wd_clear = !in_wait || (state_d != state_q);

  ctrl_watchdog #(
    .WIDTH_CNT (WIDTH_CNT),
    .TIMEOUT   (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (wd_clear),
    .en_i      (in_wait),
    .expired_o (wd_expired)
  );

  // Next state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    bkt_lvl_d = bkt_lvl_q;
    n_dec_d   = n_dec_q;
    n_conf_d  = n_conf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start_i) begin
          state_d  = S_BCP;
          res_d    = '0;
          n_dec_d  = '0;
          n_conf_d = '0;
        end
      end
      S_BCP: state_d = S_WAIT_BCP;
      S_WAIT_BCP: begin
        // A done in the last watchdog cycle still takes the normal path.
        if (bus.bcp_done_i) begin
          if (!bus.conflict_i) begin
            state_d = S_DECIDE;
          end else if (bus.cur_lvl_i <= bus.base_lvl_i) begin
            state_d = S_DONE;
            res_d   = result_onehot(RES_UNSAT);
          end else begin
            state_d  = S_ANALYZE;
            n_conf_d = (n_conf_q == CNT_MAX) ? n_conf_q : n_conf_q + WIDTH_CNT'(1);
          end
        end else if (wd_expired) begin
          state_d = S_DONE;
          res_d   = result_onehot(RES_TIMEOUT);
        end
      end
      S_DECIDE: begin
        // The decision is counted as the pulse leaves, so it stays counted
        // even when the unit reports no free variable.
        state_d = S_WAIT_DCD;
        n_dec_d = (n_dec_q == CNT_MAX) ? n_dec_q : n_dec_q + WIDTH_CNT'(1);
      end
      S_WAIT_DCD: begin
        if (bus.decision_done_i) begin
          if (bus.index_decided_i == NUM_VARS'(0)) begin
            state_d = S_DONE;
            res_d   = result_onehot(RES_SAT);
          end else begin
            state_d = S_BCP;
          end
        end else if (wd_expired) begin
          state_d = S_DONE;
          res_d   = result_onehot(RES_TIMEOUT);
        end
      end
      S_ANALYZE: state_d = S_WAIT_AN;
      S_WAIT_AN: begin
        if (bus.analyze_done_i) begin
          bkt_lvl_d = bus.bkt_lvl_i;
          if (bus.bkt_lvl_i < bus.base_lvl_i) begin
            state_d = S_DONE;
            res_d   = result_onehot(RES_BKT_OUT);
          end else begin
            state_d = S_BKT;
          end
        end else if (wd_expired) begin
          state_d = S_DONE;
          res_d   = result_onehot(RES_TIMEOUT);
        end
      end
      S_BKT:   state_d = S_BCP;
      default: state_d = S_IDLE;
    endcase

    // BCP, analysis and backtrack requests coincide with their state; the
    // decision request is issued on leaving DECIDE (two cycles after bcp_done).
    bcp_start_d = (state_d == S_BCP);
    an_start_d  = (state_d == S_ANALYZE);
    apply_d     = (state_d == S_BKT);
    dec_pulse_d = (state_q == S_DECIDE);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State and output registers; reset aborts any run without a pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      dec_pulse_q <= 1'b0;
      bcp_start_q <= 1'b0;
      an_start_q  <= 1'b0;
      apply_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_q       <= '0;
      bkt_lvl_q   <= '0;
      n_dec_q     <= '0;
      n_conf_q    <= '0;
    end else begin
      state_q     <= state_d;
      dec_pulse_q <= dec_pulse_d;
      bcp_start_q <= bcp_start_d;
      an_start_q  <= an_start_d;
      apply_q     <= apply_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_q       <= res_d;
      bkt_lvl_q   <= bkt_lvl_d;
      n_dec_q     <= n_dec_d;
      n_conf_q    <= n_conf_d;
    end
  end

  assign bus.decision_pulse_o = dec_pulse_q;
  assign bus.bcp_start_o      = bcp_start_q;
  assign bus.analyze_start_o  = an_start_q;
  assign bus.apply_bkt_o      = apply_q;
  assign bus.bkt_lvl_o        = bkt_lvl_q;
  assign bus.busy_o           = busy_q;
  assign bus.done_o           = done_q;
  assign bus.sat_o            = res_q[RES_SAT];
  assign bus.unsat_o          = res_q[RES_UNSAT];
  assign bus.bkt_out_o        = res_q[RES_BKT_OUT];
  assign bus.timeout_o        = res_q[RES_TIMEOUT];
  assign bus.n_decisions_o    = n_dec_q;
  assign bus.n_conflicts_o    = n_conf_q;
  assign bus.dbg_state_o      = state_q;
endmodule

// File: tb/tb_search_ctrl.sv
// Bench for search_ctrl: directed runs with engine responders, a scoreboard of
// expected run results checked when done_o rises, and timing spot checks.
module tb_search_ctrl;
  import search_ctrl_pkg::*;

  localparam int W  = 52;  // {result[3:0], n_decisions, n_conflicts, bkt_lvl}
  localparam int TO = DEF_TIMEOUT;
  localparam logic [3:0] R_SAT   = 4'b0001;
  localparam logic [3:0] R_UNSAT = 4'b0010;
  localparam logic [3:0] R_BKT   = 4'b0100;
  localparam logic [3:0] R_TO    = 4'b1000;

  logic clk;
  logic rst;
  search_ctrl_if bus();

  search_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int             n_checks;
  int             n_fail;
  logic [W-1:0]   exp_q[$];
  logic [15:0]    model_bkt;
  int             bcp_cnt, an_cnt, apply_cnt;
  int             b0, a0, p0;
  logic           done_prev;
  logic [3:0]     pulse_prev;
  logic [3:0]     pulses_now;
  logic [9:0]     flags_now;
  logic [W-1:0]   exp_e;

  assign pulses_now = {bus.decision_pulse_o, bus.bcp_start_o,
                       bus.analyze_start_o, bus.apply_bkt_o};
  assign flags_now  = {pulses_now, bus.busy_o, bus.done_o, bus.sat_o,
                       bus.unsat_o, bus.bkt_out_o, bus.timeout_o};

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL tb_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] act,
                          input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_exp(input logic [3:0] res,
      input logic [15:0] nd, input logic [15:0] nc, input logic [15:0] bk);
    return {res, nd, nc, bk};
  endfunction

  // Monitor: pulse width, pulse counts, and scoreboard on each rising done_o.
  always @(negedge clk) begin
    if (pulses_now != 4'b0000) check_eq("pulse_width", pulses_now & pulse_prev, 0);
    if (bus.bcp_start_o)     bcp_cnt   <= bcp_cnt + 1;
    if (bus.analyze_start_o) an_cnt    <= an_cnt + 1;
    if (bus.apply_bkt_o)     apply_cnt <= apply_cnt + 1;
    if (bus.done_o && !done_prev) begin
      check_eq("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check_eq("sb_result", {bus.timeout_o, bus.bkt_out_o, bus.unsat_o, bus.sat_o},
                 exp_e[51:48]);
        check_eq("sb_n_decisions", bus.n_decisions_o, exp_e[47:32]);
        check_eq("sb_n_conflicts", bus.n_conflicts_o, exp_e[31:16]);
        check_eq("sb_bkt_lvl", bus.bkt_lvl_o, exp_e[15:0]);
      end
    end
    pulse_prev <= pulses_now;
    done_prev  <= bus.done_o;
  end

  // driver tasks (all start and end on a falling edge)
  task automatic do_start(input logic [15:0] base);
    bus.start_i    = 1'b1;
    bus.base_lvl_i = base;
    @(negedge clk);
    bus.start_i    = 1'b0;
  endtask

  task automatic respond_bcp_now(input logic conflict);
    bus.bcp_done_i = 1'b1;
    bus.conflict_i = conflict;
    @(negedge clk);
    bus.bcp_done_i = 1'b0;
    bus.conflict_i = 1'b0;
  endtask

  // Called in the cycle bcp_start_o is seen; answers in the first WAIT cycle.
  task automatic respond_bcp(input logic conflict);
    @(negedge clk);
    respond_bcp_now(conflict);
  endtask

  // Called in the cycle decision_pulse_o is seen.
  task automatic respond_dcd(input logic [7:0] idx);
    bus.decision_done_i = 1'b1;
    bus.index_decided_i = idx;
    @(negedge clk);
    bus.decision_done_i = 1'b0;
    bus.index_decided_i = 8'hA5;
  endtask

  // Called in the cycle analyze_start_o is seen.
  task automatic respond_an(input logic [15:0] lvl);
    @(negedge clk);
    bus.analyze_done_i = 1'b1;
    bus.bkt_lvl_i      = lvl;
    @(negedge clk);
    bus.analyze_done_i = 1'b0;
    bus.bkt_lvl_i      = 16'hBEEF;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; model_bkt = 16'd0;
    bcp_cnt = 0; an_cnt = 0; apply_cnt = 0;
    bus.start_i = 1'b0; bus.base_lvl_i = '0; bus.decision_done_i = 1'b0;
    bus.index_decided_i = '0; bus.cur_lvl_i = '0; bus.bcp_done_i = 1'b0;
    bus.conflict_i = 1'b0; bus.analyze_done_i = 1'b0; bus.bkt_lvl_i = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_flags", flags_now, 0);
    check_eq("reset_bkt_lvl", bus.bkt_lvl_o, 0);
    check_eq("reset_counters", {bus.n_decisions_o, bus.n_conflicts_o}, 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: four decisions, last one finds no free variable -> SAT
    exp_q.push_back(pack_exp(R_SAT, 16'd4, 16'd0, model_bkt));
    bus.cur_lvl_i = 16'd0;
    do_start(16'd0);
    check_eq("t1_start_latency", bus.bcp_start_o, 1);
    check_eq("t1_busy", bus.busy_o, 1);
    respond_bcp(1'b0);
    check_eq("t1_dcd_not_early", bus.decision_pulse_o, 0);
    @(negedge clk);
    check_eq("t1_bcp_to_dcd_latency", bus.decision_pulse_o, 1);
    check_eq("t1_n_dec_first", bus.n_decisions_o, 1);
    for (int i = 0; i < 3; i++) begin
      respond_dcd(8'h01);
      check_eq("t1_bcp_after_dcd", bus.bcp_start_o, 1);
      respond_bcp(1'b0);
      @(negedge clk);
      check_eq("t1_dcd_pulse", bus.decision_pulse_o, 1);
    end
    respond_dcd(8'h00);
    repeat (3) @(negedge clk);
    check_eq("t1_done_held", {bus.done_o, bus.sat_o, bus.busy_o}, 3'b110);

    // 2: conflict at the base level -> UNSAT after one BCP, no analysis
    exp_q.push_back(pack_exp(R_UNSAT, 16'd0, 16'd0, model_bkt));
    bus.cur_lvl_i = 16'd5;
    b0 = bcp_cnt; a0 = an_cnt;
    do_start(16'd5);
    respond_bcp(1'b1);
    @(negedge clk);
    check_eq("t2_bcp_count", bcp_cnt - b0, 1);
    check_eq("t2_no_analyze", an_cnt - a0, 0);

    // 3: conflict above base, backtrack to 4, then continue to SAT
    exp_q.push_back(pack_exp(R_SAT, 16'd1, 16'd1, 16'd4));
    bus.cur_lvl_i = 16'd7;
    do_start(16'd3);
    respond_bcp(1'b1);
    check_eq("t3_analyze_pulse", bus.analyze_start_o, 1);
    check_eq("t3_n_conflicts", bus.n_conflicts_o, 1);
    respond_an(16'd4);
    model_bkt = 16'd4;
    check_eq("t3_apply_pulse", bus.apply_bkt_o, 1);
    check_eq("t3_bkt_lvl_during_apply", bus.bkt_lvl_o, model_bkt);
    @(negedge clk);
    check_eq("t3_apply_then_bcp", {bus.apply_bkt_o, bus.bcp_start_o}, 2'b01);
    check_eq("t3_bkt_lvl_stable", bus.bkt_lvl_o, model_bkt);
    respond_bcp(1'b0);
    @(negedge clk);
    check_eq("t3_dcd_pulse", bus.decision_pulse_o, 1);
    respond_dcd(8'h00);

    // 4: backtrack below base -> out of bin, no backtrack pulse
    exp_q.push_back(pack_exp(R_BKT, 16'd0, 16'd1, 16'd2));
    p0 = apply_cnt;
    do_start(16'd3);
    respond_bcp(1'b1);
    respond_an(16'd2);
    model_bkt = 16'd2;
    @(negedge clk);
    check_eq("t4_no_apply", apply_cnt - p0, 0);

    // 5a: bcp_done withheld -> timeout after TIMEOUT cycles in WAIT_BCP
    exp_q.push_back(pack_exp(R_TO, 16'd0, 16'd0, model_bkt));
    bus.cur_lvl_i = 16'd0;
    do_start(16'd0);
    repeat (TO) @(negedge clk);
    check_eq("t5_not_early", bus.done_o, 0);
    @(negedge clk);
    check_eq("t5_timeout_done", {bus.done_o, bus.timeout_o}, 2'b11);

    // 5b: done in the final watchdog cycle wins over the timeout
    exp_q.push_back(pack_exp(R_SAT, 16'd1, 16'd0, model_bkt));
    do_start(16'd0);
    repeat (TO) @(negedge clk);
    respond_bcp_now(1'b0);
    check_eq("t5_late_done_wins", {bus.done_o, bus.busy_o}, 2'b01);
    @(negedge clk);
    check_eq("t5_dcd_pulse", bus.decision_pulse_o, 1);
    respond_dcd(8'h00);

    // 6a: reset while waiting for analysis, start held during reset
    bus.cur_lvl_i = 16'd7;
    do_start(16'd3);
    respond_bcp(1'b1);
    @(negedge clk);
    check_eq("t6_in_wait_an", bus.dbg_state_o, ST_WAIT_AN);
    rst = 1'b0;
    bus.start_i = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_flags", flags_now, 0);
    check_eq("t6_rst_bkt_lvl", bus.bkt_lvl_o, 0);
    check_eq("t6_rst_counters", {bus.n_decisions_o, bus.n_conflicts_o}, 0);
    bus.start_i = 1'b0;
    model_bkt = 16'd0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_idle_after_rst", {bus.dbg_state_o, flags_now}, {ST_IDLE, 10'd0});

    // 6b: start and stray done inputs while busy are ignored
    exp_q.push_back(pack_exp(R_SAT, 16'd1, 16'd0, model_bkt));
    bus.cur_lvl_i = 16'd0;
    b0 = bcp_cnt;
    do_start(16'd0);
    @(negedge clk);
    bus.start_i = 1'b1; bus.analyze_done_i = 1'b1;
    bus.decision_done_i = 1'b1; bus.index_decided_i = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t6_busy_inputs_ignored", {bus.bcp_start_o, bus.dbg_state_o},
               {1'b0, ST_WAIT_BCP});
    end
    bus.start_i = 1'b0; bus.analyze_done_i = 1'b0;
    bus.decision_done_i = 1'b0; bus.index_decided_i = 8'hA5;
    respond_bcp_now(1'b0);
    @(negedge clk);
    check_eq("t6_dcd_pulse", bus.decision_pulse_o, 1);
    respond_dcd(8'h00);
    @(negedge clk);
    check_eq("t6_single_bcp", bcp_cnt - b0, 1);

    // final report
    @(negedge clk);
    check_eq("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
